bgm_sequencer: RTL and testbench

- Parametrised background-music player: walks a per-track note table in external synchronous memory at a fixed beat rate.
- Drives CHANNELS tone frequencies (Hz) to the game's audio path.
- Successor to the fixed two-channel, per-state tune modules: one instance serves every game state via `track`.
- Adds looping, end-of-track detection, track-switch restart and rest encoding.

---
 rtl/bgm_sequencer.sv | 146 ++++++++++++++
 tb/tb_bgm_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bgm_sequencer.sv
// Background-music sequencer: steps through {track, step} note words in a
// synchronous memory at a fixed beat rate and drives per-channel tone frequencies.
module bgm_sequencer #(
  parameter int          CHANNELS  = 2,
  parameter int          NOTE_W    = 32,
  parameter int          TRACK_W   = 4,
  parameter int          STEP_W    = 8,
  parameter int          BEAT_DIV  = 12500000,
  parameter int unsigned REST_FREQ = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [TRACK_W-1:0]           track,
  input  logic                         loop_en,
  output logic [TRACK_W+STEP_W-1:0]    mem_addr,
  input  logic [CHANNELS*NOTE_W:0]     mem_data,
  output logic [CHANNELS*NOTE_W-1:0]   freq,
  output logic                         playing,
  output logic                         done
);

  localparam int FW    = CHANNELS * NOTE_W;
  localparam int CNT_W = $clog2(BEAT_DIV);
  localparam logic [NOTE_W-1:0] REST     = NOTE_W'(REST_FREQ);
  localparam logic [FW-1:0]     REST_ALL = {CHANNELS{REST}};
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BEAT_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]     beat_q, beat_d;
  logic [TRACK_W-1:0]   trk_q, trk_d;
  logic [FW-1:0]        freq_q, freq_d;
  logic                 playing_q, playing_d;
  logic                 done_q, done_d;
  logic                 end_flag;

  assign end_flag = mem_data[FW];
  assign mem_addr = {trk_q, step_q};
  assign freq     = freq_q;
  assign playing  = playing_q;
  assign done     = done_q;

  // en=0 outranks a track change, which in turn outranks per-state handling.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    beat_d  = beat_q;
    trk_d   = trk_q;
    freq_d  = freq_q;
    if (!en) begin
      state_d = S_IDLE;
      step_d  = '0;
      beat_d  = '0;
      freq_d  = REST_ALL;
    end else if (state_q != S_IDLE && track != trk_q) begin
      state_d = S_FETCH;
      trk_d   = track;
      step_d  = '0;
      beat_d  = '0;
      freq_d  = REST_ALL;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
          trk_d   = track;
          step_d  = '0;
          beat_d  = '0;
        end
        S_FETCH: begin
          state_d = S_LATCH;
          beat_d  = beat_q + 1'b1;
        end
        S_LATCH: begin
          beat_d = beat_q + 1'b1;
          if (!end_flag) begin
            state_d = S_PLAY;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
              freq_d[k*NOTE_W +: NOTE_W] = (mem_data[k*NOTE_W +: NOTE_W] == '0)
                                           ? REST : mem_data[k*NOTE_W +: NOTE_W];
            end
          end else if (loop_en && step_q != '0) begin
            state_d = S_FETCH;
            step_d  = '0;
            beat_d  = '0;
          end else begin
            state_d = S_DONE;
            freq_d  = REST_ALL;
          end
        end
        S_PLAY: begin
          if (beat_q == LAST) begin
            state_d = S_FETCH;
            step_d  = step_q + 1'b1;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          step_d  = '0;
          beat_d  = '0;
          freq_d  = REST_ALL;
        end
      endcase
    end
  end

  always_comb begin
    playing_d = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_PLAY);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      beat_q    <= '0;
      trk_q     <= '0;
      freq_q    <= REST_ALL;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      beat_q    <= beat_d;
      trk_q     <= trk_d;
      freq_q    <= freq_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_bgm_sequencer.sv
// Directed bench for bgm_sequencer: step-timed reference model checked every cycle,
// plus hand-computed literal checkpoints.
module tb_bgm_sequencer;

  localparam int BD = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  track;
  logic        loop_en;
  logic [11:0] mem_addr;
  logic [64:0] mem_data;
  logic [63:0] freq;
  logic        playing;
  logic        done;

  logic [64:0] mem [0:4095];

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  bgm_sequencer #(
    .CHANNELS (2),
    .NOTE_W   (32),
    .TRACK_W  (4),
    .STEP_W   (8),
    .BEAT_DIV (BD),
    .REST_FREQ(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .track   (track),
    .loop_en (loop_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .freq    (freq),
    .playing (playing),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  localparam logic [63:0] REST2 = {32'd1, 32'd1};

  function automatic logic [63:0] pk(input int unsigned c0, input int unsigned c1);
    return {c1[31:0], c0[31:0]};
  endfunction

  function automatic logic [63:0] restmap(input logic [63:0] w);
    logic [63:0] r;
    r = w;
    if (w[31:0] == 32'd0)  r[31:0]  = 32'd1;
    if (w[63:32] == 32'd0) r[63:32] = 32'd1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 running a step, 2 finished; ph = cycle within step.
  int          m_mode;
  int          m_ph;
  logic [3:0]  m_trk;
  logic [7:0]  m_step;
  logic [63:0] m_freq;
  logic [64:0] m_word;

  assign m_word = mem[{m_trk, m_step}];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_ph <= 0; m_trk <= '0; m_step <= '0; m_freq <= REST2;
    end else if (!en) begin
      m_mode <= 0; m_step <= '0; m_freq <= REST2;
    end else if (m_mode != 0 && track != m_trk) begin
      m_mode <= 1; m_ph <= 0; m_trk <= track; m_step <= '0; m_freq <= REST2;
    end else if (m_mode == 0) begin
      m_mode <= 1; m_ph <= 0; m_trk <= track; m_step <= '0;
    end else if (m_mode == 1) begin
      if (m_ph == 1) begin
        if (!m_word[64]) begin
          m_freq <= restmap(m_word[63:0]);
          m_ph   <= 2;
        end else if (loop_en && m_step != 8'd0) begin
          m_step <= '0;
          m_ph   <= 0;
        end else begin
          m_freq <= REST2;
          m_mode <= 2;
        end
      end else if (m_ph == BD - 1) begin
        m_step <= m_step + 8'd1;
        m_ph   <= 0;
      end else begin
        m_ph <= m_ph + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mem_addr", 64'(mem_addr), 64'({m_trk, m_step}));
      chk("freq", freq, m_freq);
      chk("playing", 64'(playing), 64'(m_mode == 1));
      chk("done", 64'(done), 64'(m_mode == 2));
      chk("exclusive", 64'(playing & done), 64'd0);
    end
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h300] = {1'b0, pk(440, 262)};
    mem[12'h301] = {1'b0, pk(494, 0)};
    mem[12'h302] = {1'b1, pk(523, 330)};
    mem[12'h500] = {1'b1, pk(600, 700)};
    mem[12'h700] = {1'b0, pk(1000, 2000)};
    mem[12'h701] = {1'b1, pk(0, 0)};
    for (int s = 0; s < 256; s++) mem[{4'h9, 8'(s)}] = {1'b0, pk(s * 3 + 7, s + 100)};

    rst = 1'b0; en = 1'b0; track = 4'h0; loop_en = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset freq", freq, REST2);
    chk("reset playing", 64'(playing), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset addr", 64'(mem_addr), 64'd0);
    started = 1;
    w(2);
    rst = 1'b0;

    // Track 3, no loop
    w(1); en = 1'b1; track = 4'h3; loop_en = 1'b0;
    w(1);  chk("t1 addr0", 64'(mem_addr), 64'h300); chk("t1 playing", 64'(playing), 64'd1);
    w(2);  chk("t1 note0", freq, pk(440, 262));
    w(4);  chk("t1 note1 rest", freq, pk(494, 1));
    w(2);  chk("t1 addr2", 64'(mem_addr), 64'h302);
    w(2);  chk("t1 end freq", freq, REST2); chk("t1 done", 64'(done), 64'd1);
           chk("t1 not playing", 64'(playing), 64'd0);
    w(4);  chk("t1 done hold addr", 64'(mem_addr), 64'h302);
    en = 1'b0;
    w(1);  chk("t1 idle done", 64'(done), 64'd0); chk("t1 idle addr", 64'(mem_addr), 64'h300);

    // Track 3 looping
    en = 1'b1; loop_en = 1'b1;
    w(11); chk("t2 refetch addr", 64'(mem_addr), 64'h300); chk("t2 hold", freq, pk(494, 1));
           chk("t2 no done", 64'(done), 64'd0);
    w(1);  chk("t2 hold2", freq, pk(494, 1));
    w(1);  chk("t2 relatch", freq, pk(440, 262));
    w(12);
    en = 1'b0;
    w(2);

    // Track 5: end flag at step 0 never loops
    en = 1'b1; track = 4'h5; loop_en = 1'b1;
    w(3);  chk("t3 done", 64'(done), 64'd1); chk("t3 freq", freq, REST2);
    w(3);  chk("t3 no refetch", 64'(mem_addr), 64'h500);
    track = 4'h3;
    w(1);  chk("t3 restart addr", 64'(mem_addr), 64'h300); chk("t3 restart playing", 64'(playing), 64'd1);
    w(2);  chk("t3 restart note", freq, pk(440, 262));

    // Track change mid-play
    w(4);  chk("t4 step1", freq, pk(494, 1));
    track = 4'h7;
    w(1);  chk("t4 switch freq", freq, REST2); chk("t4 switch addr", 64'(mem_addr), 64'h700);
    w(2);  chk("t4 first note", freq, pk(1000, 2000));

    // Asynchronous reset between edges
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("t5 async freq", freq, REST2);
    chk("t5 async playing", 64'(playing), 64'd0);
    chk("t5 async addr", 64'(mem_addr), 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    w(1);  chk("t5 restart addr", 64'(mem_addr), 64'h700); chk("t5 restart playing", 64'(playing), 64'd1);
    w(2);  chk("t5 note", freq, pk(1000, 2000));
    w(9);
    en = 1'b0; track = 4'h9;
    w(1);  chk("t5 en priority addr", 64'(mem_addr), 64'h700); chk("t5 en priority playing", 64'(playing), 64'd0);

    // 256-step wrap on track 9
    en = 1'b1; loop_en = 1'b0;
    w(1);    chk("t6 addr0", 64'(mem_addr), 64'h900);
    w(1020); chk("t6 addr ff", 64'(mem_addr), 64'h9FF);
    w(4);    chk("t6 wrap addr", 64'(mem_addr), 64'h900);
    w(2);    chk("t6 wrap note", freq, pk(7, 100));
    w(2);    chk("t6 addr1", 64'(mem_addr), 64'h901);
    en = 1'b0;
    w(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
